// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-order queue of fetched {pc, predicted next-pc}
// pairs. Execute resolves the oldest entry; the block emits the predictor
// update (1-cycle registered pulse) and, on mispredict, flushes the queue and
// emits a one-cycle redirect.
// Optional feature: define BRANCH_STATS_EN to add saturating stat_cf and
// stat_mispred counters.
module branch_resolution_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  input  logic [XLEN-1:0]  enq_pc,
  input  logic [XLEN-1:0]  enq_pred_npc,
  output logic             enq_ready,
  input  logic             res_valid,
  input  logic             res_is_cf,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             upd_we,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
`ifdef BRANCH_STATS_EN
  output logic [31:0]      stat_cf,
  output logic [31:0]      stat_mispred,
`endif
  output logic             err_underflow
);

  typedef enum logic {NORMAL, REDIRECT} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   mem_pc  [DEPTH];
  logic [XLEN-1:0]   mem_npc [DEPTH];
  logic [PTR_W-1:0]  rptr, wptr;
  logic              do_enq, do_res, mispredict;
  logic [XLEN-1:0]   actual_npc;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  // Not pop-aware: a full queue refuses enqueue even while resolving.
  assign enq_ready = !full && (state == NORMAL);

  // Resolve decode: correct next pc of the oldest entry and mispredict check.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    do_enq     = enq_valid && enq_ready;
    do_res     = res_valid && !empty && (state == NORMAL);
    actual_npc = (res_is_cf && res_taken) ? res_target : mem_pc[rptr] + XLEN'(4);
    mispredict = do_res && (actual_npc != mem_npc[rptr]);
    state_next = NORMAL;
    if (state == NORMAL && mispredict) state_next = REDIRECT;
  end

  // State register, pointers, count, sticky error and registered output pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state          <= NORMAL;
      rptr           <= '0;
      wptr           <= '0;
      count          <= '0;
      err_underflow  <= 1'b0;
      upd_we         <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_next;
      upd_we         <= do_res && res_is_cf;
      redirect_valid <= mispredict;
      if (do_res) begin
        upd_pc      <= mem_pc[rptr];
        upd_target  <= res_target;
        upd_taken   <= res_taken;
        redirect_pc <= actual_npc;
      end
      if (res_valid && empty && state == NORMAL) err_underflow <= 1'b1;
      if (mispredict) begin
        // Flush wrong-path entries; a same-cycle enqueue is dropped.
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (do_enq) wptr <= wptr + 1'b1;
        if (do_res) rptr <= rptr + 1'b1;
        count <= count + (PTR_W+1)'(do_enq) - (PTR_W+1)'(do_res);
      end
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; entries are only read once
    // count says they hold valid data.
    if (do_enq && !mispredict) begin
      mem_pc[wptr]  <= enq_pc;
      mem_npc[wptr] <= enq_pred_npc;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cf      <= '0;
      stat_mispred <= '0;
    end else begin
      if (do_res && res_is_cf && stat_cf != '1) stat_cf <= stat_cf + 32'd1;
      if (mispredict && stat_mispred != '1)     stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
